// File: rtl/vga_line_doubler.sv
// rtl/vga_line_doubler.sv - VGA-domain line doubler: FIFO pop, 2-bank line buffer, 2x2 scaled RGB888 out
//
// Pops 320x240 RGB565 source pixels from the SDRAM->VGA FIFO into a two-bank
// line buffer. One bank is displayed while the other is filled with the next
// source line. Each source pixel covers two columns and each source line
// covers two rows, giving a 640x480 image.
//
// Ports:
//   clk_vga          in   pixel clock, sole clock
//   rst              in   asynchronous active-high reset
//   frame_start      in   1-cycle pulse in vertical blanking before row 0
//   video_on         in   active-area flag from the VGA timing generator
//   vga_x, vga_y     in   current column 0..639 / row 0..479
//   fifo_read_enable out  FIFO pop; word valid on fifo_read_data next cycle
//   fifo_read_data   in   FIFO word, RGB565 {r[15:11], g[10:5], b[4:0]}
//   fifo_empty       in   FIFO empty flag
//   vga_r/g/b        out  8-bit colour, aligned with video_on_d
//   video_on_d       out  video_on delayed one cycle
//   underflow        out  sticky: a line was incomplete when its bank swapped in
//   underflow_count  out  saturating count of underflow events
module vga_line_doubler #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk_vga,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  video_on,
  input  logic [9:0]            vga_x,
  input  logic [9:0]            vga_y,
  output logic                  fifo_read_enable,
  input  logic [DATA_WIDTH-1:0] fifo_read_data,
  input  logic                  fifo_empty,
  output logic [7:0]            vga_r,
  output logic [7:0]            vga_g,
  output logic [7:0]            vga_b,
  output logic                  video_on_d,
  output logic                  underflow,
  output logic [15:0]           underflow_count
);

  localparam logic [8:0] W9       = 9'(IMG_WIDTH);
  localparam logic [8:0] H9       = 9'(IMG_HEIGHT);
  localparam logic [9:0] LAST_ROW = 10'(2 * IMG_HEIGHT - 1);
  localparam int         DEPTH    = 2 * IMG_WIDTH;

  typedef enum logic [1:0] {IDLE, PREFILL, ACTIVE} state_t;

  state_t                state_q, state_d;
  logic                  disp_bank_q, disp_bank_d;
  logic [8:0]            src_line_q, src_line_d;
  logic [8:0]            wr_cnt_q, wr_cnt_d;
  logic [8:0]            issued_q, issued_d;
  logic                  rd_pending_q, rd_pending_d;
  logic                  video_on_prev_q, video_on_prev_d;
  logic                  video_on_d_q, video_on_d_d;
  logic                  show_q, show_d;
  logic                  underflow_q, underflow_d;
  logic [15:0]           underflow_count_q, underflow_count_d;
  logic [DATA_WIDTH-1:0] pix_q;

  logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];

  logic       fill_bank, fetch_active, pop, wr_en, swap, last_fall;
  logic [8:0] wr_cnt_inc;
  logic [9:0] wr_idx, rd_idx;
  logic       unused_x_lsb;

  // Column pairs share a source pixel, so the column LSB never addresses the buffer.
  assign unused_x_lsb = vga_x[0];

  // During PREFILL the bank that will be shown first is being filled.
  assign fill_bank    = (state_q == PREFILL) ? disp_bank_q : ~disp_bank_q;
  assign fetch_active = (state_q == PREFILL) ||
                        ((state_q == ACTIVE) && ((src_line_q + 9'd1) < H9));
  // No pop on frame_start: its data would be discarded and the word lost.
  assign pop          = fetch_active && !fifo_empty && (issued_q < W9) && !frame_start;
  assign fifo_read_enable = pop;

  assign wr_en      = rd_pending_q && (wr_cnt_q < W9) && !frame_start;
  assign wr_cnt_inc = wr_cnt_q + {8'd0, wr_en};
  assign swap       = (state_q == ACTIVE) && video_on && !video_on_prev_q &&
                      !vga_y[0] && (vga_y != 10'd0) && ((src_line_q + 9'd1) < H9);
  assign last_fall  = (state_q == ACTIVE) && !video_on && video_on_prev_q &&
                      (vga_y == LAST_ROW);

  // Write targets the current fill bank, so a write on the swap cycle lands in the old one.
  assign wr_idx = fill_bank ? (10'(IMG_WIDTH) + {1'b0, wr_cnt_q}) : {1'b0, wr_cnt_q};
  // Read uses the post-swap bank so the first pixel of a new row comes from the new line.
  assign rd_idx = disp_bank_d ? (10'(IMG_WIDTH) + {1'b0, vga_x[9:1]}) : {1'b0, vga_x[9:1]};

  always_comb begin
    state_d           = state_q;
    disp_bank_d       = disp_bank_q;
    src_line_d        = src_line_q;
    wr_cnt_d          = wr_cnt_inc;
    issued_d          = issued_q + {8'd0, pop};
    rd_pending_d      = pop;
    video_on_prev_d   = video_on;
    video_on_d_d      = video_on;
    show_d            = video_on && (state_q == ACTIVE) && !frame_start;
    underflow_d       = underflow_q;
    underflow_count_d = underflow_count_q;

    case (state_q)
      PREFILL: begin
        if (wr_cnt_inc == W9) begin
          state_d  = ACTIVE;
          wr_cnt_d = 9'd0;
          issued_d = 9'd0;
        end
      end
      ACTIVE: begin
        if (last_fall) begin
          state_d = IDLE;
        end else if (swap) begin
          disp_bank_d = ~disp_bank_q;
          src_line_d  = src_line_q + 9'd1;
          wr_cnt_d    = 9'd0;
          // A pop on the swap cycle already belongs to the new fill line.
          issued_d    = {8'd0, pop};
          if (wr_cnt_inc != W9) begin
            underflow_d = 1'b1;
            if (underflow_count_q != 16'hFFFF) begin
              underflow_count_d = underflow_count_q + 16'd1;
            end
          end
        end
      end
      default: ;
    endcase

    if (frame_start) begin
      state_d      = PREFILL;
      disp_bank_d  = 1'b0;
      src_line_d   = 9'd0;
      wr_cnt_d     = 9'd0;
      issued_d     = 9'd0;
      rd_pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      state_q           <= IDLE;
      disp_bank_q       <= 1'b0;
      src_line_q        <= 9'd0;
      wr_cnt_q          <= 9'd0;
      issued_q          <= 9'd0;
      rd_pending_q      <= 1'b0;
      video_on_prev_q   <= 1'b0;
      video_on_d_q      <= 1'b0;
      show_q            <= 1'b0;
      underflow_q       <= 1'b0;
      underflow_count_q <= 16'd0;
    end else begin
      state_q           <= state_d;
      disp_bank_q       <= disp_bank_d;
      src_line_q        <= src_line_d;
      wr_cnt_q          <= wr_cnt_d;
      issued_q          <= issued_d;
      rd_pending_q      <= rd_pending_d;
      video_on_prev_q   <= video_on_prev_d;
      video_on_d_q      <= video_on_d_d;
      show_q            <= show_d;
      underflow_q       <= underflow_d;
      underflow_count_q <= underflow_count_d;
    end
  end

  // Line buffer: plain dual-port RAM, no reset; outputs are gated by show_q instead.
  always_ff @(posedge clk_vga) begin
    if (wr_en) begin
      mem_q[wr_idx] <= fifo_read_data;
    end
    pix_q <= mem_q[rd_idx];
  end

  // RGB565 -> RGB888 by replicating the top bits into the new LSBs.
  assign vga_r = show_q ? {pix_q[15:11], pix_q[15:13]} : 8'd0;
  assign vga_g = show_q ? {pix_q[10:5],  pix_q[10:9]}  : 8'd0;
  assign vga_b = show_q ? {pix_q[4:0],   pix_q[4:2]}   : 8'd0;

  assign video_on_d      = video_on_d_q;
  assign underflow       = underflow_q;
  assign underflow_count = underflow_count_q;

endmodule
